uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the TX FIFO write port of one uart_transceiver among NUM_REQ byte-stream requesters.
//   Arbitration is round-robin and packet-locked: a granted requester keeps the UART until it
//   sends a byte flagged last, or until MAX_BURST bytes have been accepted.
//   Sits between the on-chip message sources and the uart_transceiver w_data/wr_uart/tx_full port.
// PARAMETERS
//   NUM_REQ    4   number of requesters (2..8)
//   MAX_BURST  16  max bytes per grant before forced release (1..255)
//   IDLE_TMO   64  cycles a granted requester may hold req_valid low mid-packet before release (1..255)
// PORTS
//   clk         in   1          system clock
//   reset_n     in   1          asynchronous active-low reset
//   req_valid   in   NUM_REQ    per-requester byte valid
//   req_data    in   8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
//   req_last    in   NUM_REQ    byte is last of packet
//   req_ready   out  NUM_REQ    byte accepted this cycle (valid & ready = transfer)
//   grant_id    out  3          index of current owner; valid only while busy=1
//   busy        out  1          a requester currently owns the UART
//   w_data      out  8          to uart_transceiver w_data
//   wr_uart     out  1          to uart_transceiver wr_uart (one-cycle pulse per byte)
//   tx_full     in   1          from uart_transceiver tx_full
//   tmo_evt     out  1          one-cycle pulse when a grant is released by IDLE_TMO
// BEHAVIOUR
//   Reset (async): state=IDLE, busy=0, grant_id=0, last_grant=NUM_REQ-1 (req 0 has first priority),
//     burst_cnt=0, tmo_cnt=0, tmo_evt=0. req_ready, wr_uart and w_data follow the comb rules below
//     and are therefore 0 in reset.
//   FSM states: IDLE and GRANT.
//   IDLE
//     - If any req_valid: search from last_grant+1 upward, modulo NUM_REQ; take the first valid.
//     - Register grant_id, set busy=1 and go to GRANT. Arbitration latency is 1 cycle.
//     - No byte is accepted in IDLE.
//   GRANT, g = grant_id
//     - xfer = req_valid[g] & ~tx_full.
//     - req_ready[g] = ~tx_full; all other req_ready bits = 0.
//     - wr_uart = xfer and w_data = req_data[g], both combinational from registered g.
//     - When wr_uart=0, w_data = 8'h00.
//   Release conditions (all exit to IDLE next cycle):
//     - xfer & req_last[g].
//     - xfer when burst_cnt = MAX_BURST-1.
//     - tmo_cnt reaches IDLE_TMO-1 while req_valid[g]=0. tmo_evt pulses in this case.
//     On release: last_grant<=g, busy<=0, burst_cnt<=0, tmo_cnt<=0.
//   Counters:
//     - burst_cnt increments on each xfer.
//     - tmo_cnt increments each GRANT cycle with req_valid[g]=0. It clears on req_valid[g]=1.
//     - tx_full stalls do not advance tmo_cnt; a full FIFO is not requester idleness.
//   Back-to-back: a released requester may be re-granted on the next IDLE cycle only if no other
//     requester is valid. Minimum gap between packets = 1 cycle (the IDLE cycle).
//   Simultaneous events: tmo and burst release cannot coincide, because xfer implies valid.
//     last and MAX_BURST together give a single release.
//   Protocol: requesters must hold req_valid/req_data stable until req_ready. A requester that drops
//     valid before a transfer is not an error; only IDLE_TMO applies.
//   Config changes (baud/dbit/parity) are not the arbiter's concern. Software changes them only
//     while busy=0 and the UART is idle.
// CONFIGURATION
//   UART_ARB_STATS_EN defined:
//     - adds output port byte_cnt [16*NUM_REQ-1:0]: per-requester saturating 16-bit count of
//       accepted bytes.
//     - adds output port tmo_cnt_total [7:0]: saturating count of tmo_evt pulses.
//     - both counters clear on reset only.
//   UART_ARB_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING (NUM_REQ=4, MAX_BURST=4, IDLE_TMO=8)
//   1. Reset, then req1 sends 3 bytes 8'h41,8'h42,8'h43 (last on 43), tx_full=0
//      -> grant_id=1 one cycle after valid; three consecutive wr_uart with those bytes; busy=0 after.
//   2. req0, req2 and req3 valid simultaneously, each sends 1-byte packets continuously
//      -> grant order 0,2,3,0,2,3; no requester is granted twice in a row.
//   3. req2 streams 6 bytes 8'h10..8'h15 with last only on 8'h15
//      -> released after 8'h13; req2 is re-granted for 8'h14,8'h15 only if no other valid.
//   4. tx_full=1 for 20 cycles mid-packet while req0 is valid
//      -> wr_uart=0 and req_ready[0]=0 throughout; no tmo_evt; transfer resumes the cycle tx_full falls.
//   5. req3 granted, sends 8'h55, then drops valid
//      -> tmo_evt pulses once after 8 idle cycles; busy=0 the following cycle.
//   6. reset_n asserted mid-packet
//      -> busy, wr_uart and req_ready go 0 immediately; after release req0 has first priority;
//      with STATS_EN, byte_cnt is 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX FIFO write port among NUM_REQ requesters.
// Define UART_ARB_STATS_EN to add per-requester byte counters and a timeout-event counter.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [7:0]             w_data,
  output logic                   wr_uart,
  input  logic                   tx_full,
  output logic                   tmo_evt
`ifdef UART_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  byte_cnt,
  output logic [7:0]             tmo_cnt_total
`endif
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] TMO_LAST   = 8'(IDLE_TMO - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  last_grant;
  logic [7:0]  burst_cnt;
  logic [7:0]  tmo_cnt;

  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic        valid_g;
  logic        last_g;
  logic [7:0]  data_g;

  logic [2:0]  pick;
  logic        any_valid;
  logic [3:0]  sum;

  logic        xfer;
  logic        release_g;
  logic        tmo_rel;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Pad to 8 requesters so a 3-bit grant index always selects in range.
  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);
  assign valid_g   = valid_pad[grant_id];
  assign last_g    = last_pad[grant_id];
  assign data_g    = data_pad[{grant_id, 3'b000} +: 8];

  assign busy = (state == GRANT);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    sum       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_grant} + 4'(k);
      if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
      if (!any_valid && valid_pad[sum[2:0]]) begin
        any_valid = 1'b1;
        pick      = sum[2:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    wr_uart   = 1'b0;
    w_data    = 8'h00;
    tmo_rel   = 1'b0;
    release_g = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) state_nxt = GRANT;
      end
      GRANT: begin
        xfer    = valid_g & ~tx_full;
        wr_uart = xfer;
        if (xfer) w_data = data_g;
        // A full FIFO is not idleness, so the timeout is frozen while tx_full.
        tmo_rel   = ~valid_g & ~tx_full & (tmo_cnt == TMO_LAST);
        release_g = (xfer & (last_g | (burst_cnt == BURST_LAST))) | tmo_rel;
        if (release_g) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = busy & (grant_id == 3'(i)) & ~tx_full;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      burst_cnt  <= '0;
      tmo_cnt    <= '0;
      tmo_evt    <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_evt <= tmo_rel;
      if (state == IDLE && any_valid) grant_id <= pick;
      if (release_g) begin
        last_grant <= grant_id;
        burst_cnt  <= '0;
        tmo_cnt    <= '0;
      end else if (state == GRANT) begin
        if (xfer) burst_cnt <= burst_cnt + 8'd1;
        if (valid_g) tmo_cnt <= '0;
        else if (!tx_full) tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

`ifdef UART_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else if (xfer && grant_id == 3'(i)) cnt <= sat_inc16(cnt);
    end
    assign byte_cnt[16*i +: 16] = cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_total <= '0;
    else if (tmo_evt) tmo_cnt_total <= sat_inc8(tmo_cnt_total);
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, IDLE_TMO=8): cycle vector table plus
// queue-fed requesters and a write scoreboard for the multi-cycle scenarios.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [2:0]  grant_id;
  logic        busy;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        tx_full = 1'b0;
  logic        tmo_evt;
`ifdef UART_ARB_STATS_EN
  logic [63:0] byte_cnt;
  logic [7:0]  tmo_cnt_total;
`endif

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_TMO(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .tmo_evt(tmo_evt)
`ifdef UART_ARB_STATS_EN
    , .byte_cnt(byte_cnt), .tmo_cnt_total(tmo_cnt_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic        busy;
    logic [2:0]  gid;
    logic        wr;
    logic [7:0]  wdata;
    logic [3:0]  ready;
  } vec_t;

  vec_t        tv [9];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [10:0] sb [$];
  logic [8:0]  src_mem [4][16];
  logic [3:0]  head [4];
  logic [3:0]  tail [4];
  logic        drive_src = 1'b0;
  logic        mon_wr, mon_busy, mon_tmo;
  logic [3:0]  mon_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [1:0] r, input logic [7:0] d, input logic l);
    src_mem[r][tail[r]] = {l, d};
    tail[r] = tail[r] + 4'd1;
  endtask

  task automatic expect_wr(input logic [2:0] g, input logic [7:0] d);
    sb.push_back({g, d});
  endtask

  task automatic drive_inputs();
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      r = 2'(i);
      if (head[r] != tail[r]) begin
        req_valid[r]                = 1'b1;
        req_data[{r, 3'b000} +: 8]  = src_mem[r][head[r]][7:0];
        req_last[r]                 = src_mem[r][head[r]][8];
      end else begin
        req_valid[r]                = 1'b0;
        req_data[{r, 3'b000} +: 8]  = 8'h00;
        req_last[r]                 = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    logic [10:0] e;
    logic [1:0]  r;
    mon_wr    = wr_uart;
    mon_busy  = busy;
    mon_tmo   = tmo_evt;
    mon_ready = req_ready;
    if (wr_uart) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr: got gid %0d data %0h expected no write", grant_id, w_data);
      end else begin
        e = sb.pop_front();
        check("wr_gid", 32'(grant_id), 32'(e[10:8]));
        check("wr_data", 32'(w_data), 32'(e[7:0]));
        check("wr_ready", 32'(req_ready), 32'(4'b0001 << e[10:8]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      r = 2'(i);
      if (req_valid[r] && req_ready[r] && head[r] != tail[r]) head[r] = head[r] + 4'd1;
    end
  endtask

  task automatic cycle();
    if (drive_src) drive_inputs();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max, output int ncyc);
    ncyc = 0;
    while (sb.size() > 0 && ncyc < max) begin
      cycle();
      ncyc++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic clear_stim();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_full   = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      head[i] = '0;
      tail[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_stim();
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(wr_uart), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_tmo", 32'(tmo_evt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses, pulse_at, busy8, bad_wr, bad_rdy, bad_tmo;

    // Cycle vectors: req1 3-byte packet, then req0 single byte stalled by tx_full.
    tv[0] = '{4'b0010, 32'h0000_4100, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tv[1] = '{4'b0010, 32'h0000_4100, 4'b0000, 1'b0, 1'b1, 3'd1, 1'b1, 8'h41, 4'b0010};
    tv[2] = '{4'b0010, 32'h0000_4200, 4'b0000, 1'b0, 1'b1, 3'd1, 1'b1, 8'h42, 4'b0010};
    tv[3] = '{4'b0010, 32'h0000_4300, 4'b0010, 1'b0, 1'b1, 3'd1, 1'b1, 8'h43, 4'b0010};
    tv[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tv[5] = '{4'b0001, 32'h0000_0077, 4'b0001, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
    tv[6] = '{4'b0001, 32'h0000_0077, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0000};
    tv[7] = '{4'b0001, 32'h0000_0077, 4'b0001, 1'b0, 1'b1, 3'd0, 1'b1, 8'h77, 4'b0001};
    tv[8] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};

    do_reset();
    drive_src = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req_valid = tv[i].valid;
      req_data  = tv[i].data;
      req_last  = tv[i].last;
      tx_full   = tv[i].full;
      if (tv[i].wr) expect_wr(tv[i].gid, tv[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("vec%0d_wr", i), 32'(wr_uart), 32'(tv[i].wr));
      check($sformatf("vec%0d_wdata", i), 32'(w_data), 32'(tv[i].wdata));
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tv[i].ready));
      if (tv[i].busy) check($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(tv[i].gid));
      monitor();
      @(posedge clk);
      #1;
    end
    drive_src = 1'b1;

    // Three simultaneous requesters with 1-byte packets rotate 0,2,3,0,2,3.
    do_reset();
    enq(2'd0, 8'hA0, 1'b1); enq(2'd0, 8'hA1, 1'b1);
    enq(2'd2, 8'hB0, 1'b1); enq(2'd2, 8'hB1, 1'b1);
    enq(2'd3, 8'hC0, 1'b1); enq(2'd3, 8'hC1, 1'b1);
    expect_wr(3'd0, 8'hA0); expect_wr(3'd2, 8'hB0); expect_wr(3'd3, 8'hC0);
    expect_wr(3'd0, 8'hA1); expect_wr(3'd2, 8'hB1); expect_wr(3'd3, 8'hC1);
    drain(40, n);
    check("rr_cycles", 32'(n), 32'd12);

    // req2 alone: burst release after 4 bytes, re-granted after one IDLE cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enq(2'd2, 8'(8'h10 + i), (i == 5));
      expect_wr(3'd2, 8'(8'h10 + i));
    end
    drain(20, n);
    check("burst_alone_cycles", 32'(n), 32'd8);

    // req2 burst release lets pending req3 in before req2 resumes.
    do_reset();
    for (int i = 0; i < 6; i++) enq(2'd2, 8'(8'h10 + i), (i == 5));
    enq(2'd3, 8'h99, 1'b1);
    expect_wr(3'd2, 8'h10); expect_wr(3'd2, 8'h11); expect_wr(3'd2, 8'h12);
    expect_wr(3'd2, 8'h13); expect_wr(3'd3, 8'h99); expect_wr(3'd2, 8'h14);
    expect_wr(3'd2, 8'h15);
    drain(20, n);
    check("burst_share_cycles", 32'(n), 32'd10);

    // tx_full stall mid-packet for 20 cycles.
    do_reset();
    enq(2'd0, 8'h20, 1'b0); enq(2'd0, 8'h21, 1'b0); enq(2'd0, 8'h22, 1'b1);
    expect_wr(3'd0, 8'h20); expect_wr(3'd0, 8'h21); expect_wr(3'd0, 8'h22);
    cycle();
    cycle();
    check("stall_first_byte", 32'(sb.size()), 32'd2);
    tx_full = 1'b1;
    bad_wr = 0; bad_rdy = 0; bad_tmo = 0;
    repeat (20) begin
      cycle();
      if (mon_wr) bad_wr++;
      if (mon_ready != 4'b0000) bad_rdy++;
      if (mon_tmo) bad_tmo++;
    end
    check("stall_wr", 32'(bad_wr), 32'd0);
    check("stall_ready", 32'(bad_rdy), 32'd0);
    check("stall_tmo", 32'(bad_tmo), 32'd0);
    tx_full = 1'b0;
    cycle();
    check("stall_resume_wr", 32'(mon_wr), 32'd1);
    drain(5, n);

    // req3 sends one byte then goes quiet: timeout release.
    do_reset();
    enq(2'd3, 8'h55, 1'b0);
    expect_wr(3'd3, 8'h55);
    cycle();
    cycle();
    check("tmo_byte_sent", 32'(sb.size()), 32'd0);
    pulses = 0; pulse_at = 0; busy8 = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (k == 8) busy8 = int'(mon_busy);
      if (mon_tmo) begin
        pulses++;
        pulse_at = k;
        check("tmo_busy_at_pulse", 32'(mon_busy), 32'd0);
      end
    end
    check("tmo_pulses", 32'(pulses), 32'd1);
    check("tmo_pulse_cycle", 32'(pulse_at), 32'd9);
    check("tmo_busy_held", 32'(busy8), 32'd1);
`ifdef UART_ARB_STATS_EN
    check("stats_tmo_total", 32'(tmo_cnt_total), 32'd1);
`endif

    // Asynchronous reset mid-packet, then req0 must regain first priority.
    do_reset();
    enq(2'd0, 8'h30, 1'b1);
    expect_wr(3'd0, 8'h30);
    drain(10, n);
    enq(2'd1, 8'h61, 1'b0); enq(2'd1, 8'h62, 1'b0); enq(2'd1, 8'h63, 1'b1);
    expect_wr(3'd1, 8'h61);
    cycle();
    cycle();
    check("rst_mid_first", 32'(sb.size()), 32'd0);
    drive_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_wr", 32'(wr_uart), 32'd0);
    check("rst_async_ready", 32'(req_ready), 32'd0);
    clear_stim();
    @(posedge clk);
    @(negedge clk);
`ifdef UART_ARB_STATS_EN
    check("stats_byte_cnt", 32'(byte_cnt != 64'd0), 32'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    enq(2'd1, 8'hA1, 1'b1);
    enq(2'd0, 8'hA0, 1'b1);
    expect_wr(3'd0, 8'hA0);
    expect_wr(3'd1, 8'hA1);
    drain(10, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
